// File: rtl/fm_mod_pkg.sv
// Shared definitions for the FM modulator: FSM encoding, fixed-point defaults,
// phase constants and the elaboration-time quarter-wave sine generator.
package fm_mod_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LOOKUP = 2'd1,
      S_OUTPUT = 2'd2
   } fm_state_t;

   localparam int          QUANT_BITS_DEF  = 10;
   localparam int          PHASE_SHIFT_DEF = 12;
   localparam int          TABLE_DEPTH     = 257;
   localparam int          ANGLE_BITS      = 10;
   localparam logic [31:0] QUARTER_TURN    = 32'h4000_0000;
   localparam logic [9:0]  QUARTER_ANGLE   = QUARTER_TURN[31:22];

   // pi in Q30; the table is only ever built from constant arguments
   localparam longint PI_Q30 = 64'sd3373259426;

   // round(2^qbits * sin(pi*i/512)) via a Q30 Taylor series; i in 0..256
   function automatic int quarter_sin(input int i, input int qbits);
      longint x;
      longint x2;
      longint term;
      longint sum;
      x    = (PI_Q30 * longint'(i)) / 64'sd512;
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int k = 1; k <= 8; k++) begin
         term = -((term * x2) >>> 30) / longint'(2 * k * (2 * k + 1));
         sum  = sum + term;
      end
      return int'(((sum <<< qbits) + (64'sd1 <<< 29)) >>> 30);
   endfunction

endpackage

// File: rtl/fm_modulate_if.sv
// Audio-in / I/Q-out FIFO handshake bundle of the FM modulator.
interface fm_modulate_if;
   logic        input_fifo_empty;
   logic        input_rd_en;
   logic [31:0] audio_in;
   logic [31:0] real_out;
   logic [31:0] imag_out;
   logic        wr_en_out;
   logic        out_fifo_full;

   modport master (
      input  input_fifo_empty,
      input  audio_in,
      input  out_fifo_full,
      output input_rd_en,
      output real_out,
      output imag_out,
      output wr_en_out
   );

   modport slave (
      output input_fifo_empty,
      output audio_in,
      output out_fifo_full,
      input  input_rd_en,
      input  real_out,
      input  imag_out,
      input  wr_en_out
   );
endinterface

// File: rtl/fm_sincos.sv
// Quarter-wave sine ROM with quadrant folding; sin/cos registered when en is high.
module fm_sincos
   import fm_mod_pkg::*;
#(
   parameter int QUANT_BITS = QUANT_BITS_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  en,
   input  logic [ANGLE_BITS-1:0] angle,
   output logic [31:0]           sin_out,
   output logic [31:0]           cos_out
);

   localparam int TW = QUANT_BITS + 1;

   logic [TW-1:0]         rom [TABLE_DEPTH];
   logic [ANGLE_BITS-1:0] cos_angle;

   for (genvar g = 0; g < TABLE_DEPTH; g++) begin : g_rom
      localparam int TV = quarter_sin(g, QUANT_BITS);
      assign rom[g] = TW'(TV);
   end

   // angle[8] mirrors the index (quadrants 1,3), angle[9] negates (quadrants 2,3)
   function automatic logic [31:0] fold(input logic [ANGLE_BITS-1:0] a);
      logic [8:0]  idx;
      logic [31:0] mag;
      idx = a[8] ? (9'd256 - {1'b0, a[7:0]}) : {1'b0, a[7:0]};
      mag = 32'(rom[idx]);
      return a[9] ? (32'd0 - mag) : mag;
   endfunction

   assign cos_angle = angle + QUARTER_ANGLE;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sin_out <= '0;
         cos_out <= '0;
      end else if (en) begin
         sin_out <= fold(angle);
         cos_out <= fold(cos_angle);
      end
   end

endmodule

// File: rtl/fm_modulate.sv
// FM modulator: pops an audio sample, advances a 32-bit phase accumulator by the
// scaled sample, and writes the cosine/sine of the new phase to the I/Q FIFOs.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | wait for audio; pop and accumulate phase when available
//   S_LOOKUP | sincos registers the lookup of the updated phase
//   S_OUTPUT | hold I/Q on the outputs; write once the output FIFO has room
module fm_modulate
   import fm_mod_pkg::*;
#(
   parameter int PHASE_SHIFT = PHASE_SHIFT_DEF,
   parameter int QUANT_BITS  = QUANT_BITS_DEF
) (
   input logic           clk,
   input logic           reset,
   fm_modulate_if.master bus
);

   fm_state_t   state;
   logic [31:0] phase;
   logic [31:0] inc;
   logic [31:0] sin_q;
   logic [31:0] cos_q;
   logic        pop;
   logic        push;

   assign inc = bus.audio_in << PHASE_SHIFT;

   // strobes are gated by reset so nothing moves while the block is held
   assign pop  = reset && (state == S_IDLE)   && !bus.input_fifo_empty;
   assign push = reset && (state == S_OUTPUT) && !bus.out_fifo_full;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IDLE;
         phase <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (!bus.input_fifo_empty) begin
                  phase <= phase + inc;
                  state <= S_LOOKUP;
               end
            end
            S_LOOKUP: state <= S_OUTPUT;
            S_OUTPUT: begin
               if (!bus.out_fifo_full) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // the sincos registers double as the captured I/Q holding registers
   fm_sincos #(
      .QUANT_BITS (QUANT_BITS)
   ) u_sincos (
      .clk     (clk),
      .reset   (reset),
      .en      (state == S_LOOKUP),
      .angle   (phase[31:22]),
      .sin_out (sin_q),
      .cos_out (cos_q)
   );

   assign bus.input_rd_en = pop;
   assign bus.wr_en_out   = push;
   assign bus.real_out    = cos_q;
   assign bus.imag_out    = sin_q;

endmodule
